// File: rtl/nios_fprint_oci_dct_monitor.sv
// DCT trace monitor for the OCI debug path.
// Watches dct_count for changes, queues {dct_count, dct_buffer} words in a
// first-word-fall-through FIFO drained over valid/ready, and on test end
// walks CAPTURE -> FLUSH -> DONE while keeping drop/discard statistics.
module nios_fprint_oci_dct_monitor #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int OVF_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          dct_buffer,
  input  logic [COUNT_W-1:0]         dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  output logic [COUNT_W+DATA_W-1:0]  out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W:0]            fifo_level,
  output logic [OVF_W-1:0]           overflow_cnt,
  output logic                       discarded,
  output logic                       done
);

  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [OVF_W-1:0]  OVF_ONE  = OVF_W'(1);
  localparam logic [OVF_W-1:0]  OVF_MAX  = '1;

  typedef enum logic [1:0] {
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // One FIFO slot; the packed layout matches out_data = {count, buffer}.
  typedef struct packed {
    logic [COUNT_W-1:0] cnt;
    logic [DATA_W-1:0]  data;
  } entry_t;

  state_t             state;
  logic [COUNT_W-1:0] dct_count_q;
  entry_t             mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;

  logic full;
  logic pop;
  logic cap_evt;
  logic push;
  logic drop;
  logic abort;
  logic abort_lost;
  logic flush_end;

  // Abort wins over everything, including a capture in the same cycle.
  assign abort      = test_has_ended;
  assign full       = (fifo_level == LVL_FULL);
  assign out_valid  = (fifo_level != '0) && (state != ST_DONE);
  assign pop        = out_valid && out_ready;
  assign cap_evt    = (state == ST_CAPTURE) && (dct_count != dct_count_q);
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push       = cap_evt && (!full || pop) && !abort;
  assign drop       = cap_evt && full && !pop && !abort;
  // Last word leaving (or nothing left) ends the flush.
  assign flush_end  = (fifo_level == '0) || ((fifo_level == LVL_ONE) && pop);
  // Entries are lost on abort unless the only one left is being popped now.
  assign abort_lost = (fifo_level != '0) && !((fifo_level == LVL_ONE) && pop);
  // FWFT head; forced to zero when nothing is valid so reset shows a clean bus.
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  // Previous dct_count, tracked in every state for change detection.
  always_ff @(posedge clk) begin
    if (reset) dct_count_q <= '0;
    else       dct_count_q <= dct_count;
  end

  // FIFO storage; contents are don't-care until the level says otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cnt: dct_count, data: dct_buffer};
  end

  // Pointers and exact occupancy; abort empties the FIFO in one step.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Saturating count of captures dropped because the FIFO was full.
  always_ff @(posedge clk) begin
    if (reset)                               overflow_cnt <= '0;
    else if (drop && overflow_cnt != OVF_MAX) overflow_cnt <= overflow_cnt + OVF_ONE;
  end

  // Test-end sequencing with registered done/discarded flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CAPTURE;
      done      <= 1'b0;
      discarded <= 1'b0;
    end else if (abort) begin
      state <= ST_DONE;
      done  <= 1'b1;
      if (abort_lost) discarded <= 1'b1;
    end else begin
      case (state)
        ST_CAPTURE: if (test_ending) state <= ST_FLUSH;
        ST_FLUSH: begin
          if (flush_end) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_fprint_oci_dct_monitor.sv
// Bench for the DCT trace monitor: table-driven capture/drain vectors plus
// hand-written end-of-test, abort, reset and saturation sequences. Words are
// pushed to a scoreboard when the stimulus should be captured and compared
// when the DUT pops them.
module tb_nios_fprint_oci_dct_monitor;

  localparam int DATA_W  = 30;
  localparam int COUNT_W = 4;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int OVF_W   = 16;
  localparam int WORD_W  = COUNT_W + DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1;
  logic [DATA_W-1:0]   dct_buffer = '0;
  logic [COUNT_W-1:0]  dct_count = '0;
  logic                test_ending = 1'b0;
  logic                test_has_ended = 1'b0;
  logic [WORD_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ADDR_W:0]     fifo_level;
  logic [OVF_W-1:0]    overflow_cnt;
  logic                discarded;
  logic                done;

  nios_fprint_oci_dct_monitor #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OVF_W(OVF_W)
  ) dut (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt),
    .discarded(discarded), .done(done)
  );

  // Small instance so the saturating counter can be driven to its ceiling quickly.
  logic        s_reset = 1'b1;
  logic [7:0]  s_buffer = '0;
  logic [3:0]  s_count = '0;
  logic [11:0] s_out_data;
  logic        s_out_valid;
  logic [2:0]  s_fifo_level;
  logic [3:0]  s_overflow_cnt;
  logic        s_discarded;
  logic        s_done;

  nios_fprint_oci_dct_monitor #(
    .DATA_W(8), .COUNT_W(4), .DEPTH(4), .ADDR_W(2), .OVF_W(4)
  ) dut_sat (
    .clk(clk), .reset(s_reset), .dct_buffer(s_buffer), .dct_count(s_count),
    .test_ending(1'b0), .test_has_ended(1'b0),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(1'b0),
    .fifo_level(s_fifo_level), .overflow_cnt(s_overflow_cnt),
    .discarded(s_discarded), .done(s_done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [WORD_W-1:0] sb [$];

  typedef struct {
    logic [COUNT_W-1:0] cnt;
    logic               rdy;
    logic               acc;
    logic [ADDR_W:0]    lvl;
    logic [OVF_W-1:0]   ovf;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Compare any word popped this cycle, then advance to just after the edge.
  task automatic cyc();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL out_data: got unexpected word 0x%0h, expected none", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(sb.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drive a count/buffer pair; record the word if it should be captured.
  task automatic ev(input logic [COUNT_W-1:0] c, input logic acc);
    logic [DATA_W-1:0] bw;
    bw = DATA_W'($urandom);
    dct_count  = c;
    dct_buffer = bw;
    if (acc) sb.push_back({c, bw});
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    out_ready      = 1'b0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    dct_count      = '0;
    cyc();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"},     64'(fifo_level),   64'(0));
    chk({tag, "_ovf"},       64'(overflow_cnt), 64'(0));
    chk({tag, "_valid"},     64'(out_valid),    64'(0));
    chk({tag, "_data"},      64'(out_data),     64'(0));
    chk({tag, "_done"},      64'(done),         64'(0));
    chk({tag, "_discarded"}, 64'(discarded),    64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc();
    do_reset();
    chk_reset_vals("reset");

    // Test 1: count 0 (no event), then 1, 2 with ready high
    tbl.push_back('{cnt: 4'd0, rdy: 1'b1, acc: 1'b0, lvl: 5'd0, ovf: 16'd0});
    tbl.push_back('{cnt: 4'd1, rdy: 1'b1, acc: 1'b1, lvl: 5'd1, ovf: 16'd0});
    tbl.push_back('{cnt: 4'd2, rdy: 1'b1, acc: 1'b1, lvl: 5'd1, ovf: 16'd0});
    tbl.push_back('{cnt: 4'd2, rdy: 1'b1, acc: 1'b0, lvl: 5'd0, ovf: 16'd0});
    // Test 2: 18 changes with ready low; the last two are dropped
    for (int i = 0; i < 18; i++)
      tbl.push_back('{cnt: 4'((3 + i) % 16), rdy: 1'b0, acc: (i < 16),
                      lvl: 5'((i < 16) ? i + 1 : 16), ovf: 16'((i < 16) ? 0 : i - 15)});
    // Test 3: full, pop and event together -> accepted, level holds
    tbl.push_back('{cnt: 4'd5, rdy: 1'b1, acc: 1'b1, lvl: 5'd16, ovf: 16'd2});
    // Drain all 16 in order
    for (int i = 0; i < 16; i++)
      tbl.push_back('{cnt: 4'd5, rdy: 1'b1, acc: 1'b0, lvl: 5'(15 - i), ovf: 16'd2});

    for (int i = 0; i < tbl.size(); i++) begin
      ev(tbl[i].cnt, tbl[i].acc);
      out_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_level", i), 64'(fifo_level),   64'(tbl[i].lvl));
      chk($sformatf("tbl%0d_ovf", i),   64'(overflow_cnt), 64'(tbl[i].ovf));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid),    64'(tbl[i].lvl != 0));
    end
    chk("tbl_sb_empty", 64'(sb.size()), 64'(0));

    // Test 4: 3 queued, test_ending with a capture in the same cycle, then drain
    out_ready = 1'b0;
    ev(4'd6, 1'b1); cyc();
    ev(4'd7, 1'b1); cyc();
    ev(4'd8, 1'b1); cyc();
    chk("flush_pre_level", 64'(fifo_level), 64'(3));
    test_ending = 1'b1;
    ev(4'd9, 1'b1);
    cyc();
    test_ending = 1'b0;
    chk("flush_same_cycle_capture", 64'(fifo_level), 64'(4));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev(4'(10 + i), 1'b0);
      cyc();
      chk($sformatf("flush%0d_level", i), 64'(fifo_level), 64'(3 - i));
      chk($sformatf("flush%0d_done", i),  64'(done),       64'(i == 3));
    end
    chk("flush_valid_off", 64'(out_valid), 64'(0));
    chk("flush_sb_empty",  64'(sb.size()), 64'(0));
    test_ending = 1'b1;
    cyc();
    test_ending = 1'b0;
    chk("done_sticky", 64'(done), 64'(1));

    // Test 5: 5 queued then abort
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      ev(4'(i), 1'b1);
      cyc();
    end
    chk("abort_pre_level", 64'(fifo_level), 64'(5));
    test_has_ended = 1'b1;
    ev(4'd6, 1'b0);
    cyc();
    test_has_ended = 1'b0;
    sb.delete();
    chk("abort_done",      64'(done),       64'(1));
    chk("abort_discarded", 64'(discarded),  64'(1));
    chk("abort_valid",     64'(out_valid),  64'(0));
    chk("abort_level",     64'(fifo_level), 64'(0));
    chk("abort_data",      64'(out_data),   64'(0));
    ev(4'd7, 1'b0);
    cyc();
    chk("abort_no_capture", 64'(fifo_level), 64'(0));
    do_reset();
    chk_reset_vals("post_abort_reset");

    // Empty FIFO: test_ending -> FLUSH, then DONE one cycle later
    test_ending = 1'b1;
    cyc();
    test_ending = 1'b0;
    chk("empty_flush_done0", 64'(done), 64'(0));
    cyc();
    chk("empty_flush_done1", 64'(done), 64'(1));

    // Test 6a: overflow, enter FLUSH, pop once, then reset mid-FLUSH
    do_reset();
    for (int i = 0; i < 18; i++) begin
      ev(4'((i + 1) % 16), i < 16);
      cyc();
    end
    chk("t6_level", 64'(fifo_level),   64'(16));
    chk("t6_ovf",   64'(overflow_cnt), 64'(2));
    test_ending = 1'b1;
    cyc();
    test_ending = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("t6_flush_level", 64'(fifo_level), 64'(15));
    chk("t6_flush_done",  64'(done),       64'(0));
    do_reset();
    chk_reset_vals("midflush_reset");

    // Test 6b: saturation on the narrow-counter instance (DEPTH 4, ceiling 15)
    s_reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      s_count  = 4'((i + 1) % 16);
      s_buffer = 8'($urandom);
      cyc();
      chk($sformatf("sat%0d_ovf", i), 64'(s_overflow_cnt),
          64'((i < 4) ? 0 : ((i - 3 > 15) ? 15 : i - 3)));
    end
    chk("sat_level", 64'(s_fifo_level), 64'(4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
